// File: rtl/cw310_aes_batch_seq.sv
`default_nettype none
//============================================================================
// Module      : cw310_aes_batch_seq
// Description : Crypto-clock sequencer that runs a batch of back-to-back
//               encryptions on an AES core. It issues each core start pulse,
//               captures each result, can chain ciphertext into the next
//               plaintext, inserts a programmable idle gap between runs and
//               guards every encryption with a watchdog.
// Ports       : crypto_clk/reset_i  - clock, synchronous active-high reset
//               I_go/I_abort        - batch start pulse / batch terminate
//               I_count/I_gap/I_chain/I_textin - batch config, sampled on go
//               I_core_ready/I_core_done/I_core_cipherout - core status/result
//               O_core_start/O_core_textin - core start pulse and plaintext
//               O_cipherout/O_completed    - last result, completion count
//               O_busy/O_batch_done/O_timeout/O_trigger - batch status
// Revision    : 1.0 - initial release
//============================================================================
module cw310_aes_batch_seq #(
  parameter int pPT_WIDTH            = 128,
  parameter int pCT_WIDTH            = 128,
  parameter int pCNT_WIDTH           = 16,
  parameter int pGAP_WIDTH           = 16,
  parameter int pTIMEOUT             = 1024,
  parameter int pDONE_EDGE_SENSITIVE = 1
) (
  input  logic                  crypto_clk,
  input  logic                  reset_i,
  input  logic                  I_go,
  input  logic                  I_abort,
  input  logic [pCNT_WIDTH-1:0] I_count,
  input  logic [pGAP_WIDTH-1:0] I_gap,
  input  logic                  I_chain,
  input  logic [pPT_WIDTH-1:0]  I_textin,
  input  logic                  I_core_ready,
  input  logic                  I_core_done,
  input  logic [pCT_WIDTH-1:0]  I_core_cipherout,
  output logic                  O_core_start,
  output logic [pPT_WIDTH-1:0]  O_core_textin,
  output logic [pCT_WIDTH-1:0]  O_cipherout,
  output logic [pCNT_WIDTH-1:0] O_completed,
  output logic                  O_busy,
  output logic                  O_batch_done,
  output logic                  O_timeout,
  output logic                  O_trigger
);

  localparam int              WD_W      = $clog2(pTIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(pTIMEOUT - 1);
  localparam logic            EDGE_MODE = (pDONE_EDGE_SENSITIVE != 0);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_READY = 3'd1,
    S_WAIT_DONE  = 3'd2,
    S_GAP        = 3'd3,
    S_FINISH     = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [pCNT_WIDTH-1:0]   count_q, count_d;
  logic [pGAP_WIDTH-1:0]   gap_q, gap_d;
  logic [pGAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
  logic                    chain_q, chain_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic                    done_q;
  logic                    core_start_q, core_start_d;
  logic [pPT_WIDTH-1:0]    core_textin_q, core_textin_d;
  logic [pCT_WIDTH-1:0]    cipherout_q, cipherout_d;
  logic [pCNT_WIDTH-1:0]   completed_q, completed_d;
  logic                    busy_q, busy_d;
  logic                    batch_done_q, batch_done_d;
  logic                    timeout_q, timeout_d;
  logic                    trigger_q, trigger_d;
  logic                    done_pulse;

  // In edge mode a done level held across several cycles counts only once.
  assign done_pulse = I_core_done & ~(done_q & EDGE_MODE);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    gap_d         = gap_q;
    gap_cnt_d     = gap_cnt_q;
    chain_d       = chain_q;
    wd_d          = wd_q;
    core_start_d  = 1'b0;
    core_textin_d = core_textin_q;
    cipherout_d   = cipherout_q;
    completed_d   = completed_q;
    busy_d        = busy_q;
    batch_done_d  = 1'b0;
    timeout_d     = timeout_q;

    if (state_q != S_IDLE && I_abort) begin
      // Abort leaves results untouched; a late core done lands in IDLE.
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (I_go && !I_abort) begin
            count_d       = I_count;
            gap_d         = I_gap;
            chain_d       = I_chain;
            core_textin_d = I_textin;
            completed_d   = '0;
            timeout_d     = 1'b0;
            busy_d        = 1'b1;
            state_d       = (I_count == '0) ? S_FINISH : S_WAIT_READY;
          end
        end
        S_WAIT_READY: begin
          if (I_core_ready) begin
            core_start_d = 1'b1;
            wd_d         = '0;
            state_d      = S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          wd_d = wd_q + WD_W'(1);
          // A done on the terminal watchdog cycle still counts as success.
          if (done_pulse) begin
            cipherout_d = I_core_cipherout;
            completed_d = completed_q + pCNT_WIDTH'(1);
            if (chain_q) begin
              core_textin_d = I_core_cipherout;
            end
            if (completed_q + pCNT_WIDTH'(1) == count_q) begin
              state_d = S_FINISH;
            end else if (gap_q == '0) begin
              state_d = S_WAIT_READY;
            end else begin
              gap_cnt_d = gap_q;
              state_d   = S_GAP;
            end
          end else if (wd_q == WD_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_FINISH;
          end
        end
        S_GAP: begin
          gap_cnt_d = gap_cnt_q - pGAP_WIDTH'(1);
          if (gap_cnt_q <= pGAP_WIDTH'(1)) begin
            state_d = S_WAIT_READY;
          end
        end
        S_FINISH: begin
          batch_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end

    // Registered view of the next state so the scope trigger has no glitches.
    trigger_d = (state_d == S_WAIT_DONE);
  end

  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      gap_q         <= '0;
      gap_cnt_q     <= '0;
      chain_q       <= 1'b0;
      wd_q          <= '0;
      done_q        <= 1'b0;
      core_start_q  <= 1'b0;
      core_textin_q <= '0;
      cipherout_q   <= '0;
      completed_q   <= '0;
      busy_q        <= 1'b0;
      batch_done_q  <= 1'b0;
      timeout_q     <= 1'b0;
      trigger_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      gap_q         <= gap_d;
      gap_cnt_q     <= gap_cnt_d;
      chain_q       <= chain_d;
      wd_q          <= wd_d;
      done_q        <= I_core_done;
      core_start_q  <= core_start_d;
      core_textin_q <= core_textin_d;
      cipherout_q   <= cipherout_d;
      completed_q   <= completed_d;
      busy_q        <= busy_d;
      batch_done_q  <= batch_done_d;
      timeout_q     <= timeout_d;
      trigger_q     <= trigger_d;
    end
  end

  assign O_core_start  = core_start_q;
  assign O_core_textin = core_textin_q;
  assign O_cipherout   = cipherout_q;
  assign O_completed   = completed_q;
  assign O_busy        = busy_q;
  assign O_batch_done  = batch_done_q;
  assign O_timeout     = timeout_q;
  assign O_trigger     = trigger_q;

endmodule
`default_nettype wire
